// File: rtl/sysx_slave_port_if.sv
// sysx_slave_port_if: sysX bus lanes plus the local TX/RX word handshakes and error flags
interface sysx_slave_port_if;
    logic        iBusClock;
    logic [1:0]  iBusSelect;
    logic [7:0]  iBusMOSI;
    logic [7:0]  oBusMISO;
    logic        oBusDrive;
    logic        oBusInterrupt;
    logic [31:0] iTxData;
    logic        iTxValid;
    logic        oTxReady;
    logic [31:0] oRxData;
    logic        oRxValid;
    logic        iRxReady;
    logic        oTxUnderrun;
    logic        oRxOverrun;
    logic        iClearFlags;

    modport master (
        output iBusClock, iBusSelect, iBusMOSI, iTxData, iTxValid, iRxReady, iClearFlags,
        input  oBusMISO, oBusDrive, oBusInterrupt, oTxReady, oRxData, oRxValid, oTxUnderrun, oRxOverrun
    );

    modport slave (
        input  iBusClock, iBusSelect, iBusMOSI, iTxData, iTxValid, iRxReady, iClearFlags,
        output oBusMISO, oBusDrive, oBusInterrupt, oTxReady, oRxData, oRxValid, oTxUnderrun, oRxOverrun
    );
endinterface

// File: rtl/sysx_slave_port.sv
// sysx_slave_port: sysX slave moving 32-bit words over an 8-bit lane; SYSX_SLAVE_IRQ_EN enables oBusInterrupt
module sysx_slave_port #(
    parameter logic [1:0] pSelect      = 2'h1,
    parameter int         pDepth       = 4,
    parameter int         pIdleTimeout = 64
) (
    input logic              iClkA,
    input logic              iReset,
    sysx_slave_port_if.slave bus
);
    localparam int AW = $clog2(pDepth);
    localparam int TW = $clog2(pIdleTimeout + 1);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, B0 = 3'd2, B1 = 3'd3, B2 = 3'd4, B3 = 3'd5, STORE = 3'd7;

    logic [1:0]    clk_s;
    logic          clk_prev;
    logic [1:0]    sel_m, sel_s;
    logic [7:0]    mosi_m, mosi_s;
    logic [2:0]    phase;
    logic [TW-1:0] idle_cnt;
    logic [31:0]   rx_shift, tx_shift;
    logic [7:0]    miso;
    logic          tx_underrun, rx_overrun;
    logic [31:0]   tx_mem [pDepth];
    logic [31:0]   rx_mem [pDepth];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [AW:0]   tx_cnt, rx_cnt;

    wire selected  = sel_s == pSelect;
    wire fall      = clk_prev & ~clk_s[1] & selected;
    wire [2:0] next_phase = (phase == STORE) ? LOAD : phase + 3'd1;
    wire load      = fall && next_phase == LOAD;
    wire store     = fall && next_phase == STORE;
    wire timeout   = phase != IDLE && idle_cnt == TW'(pIdleTimeout - 1);
    wire tx_full   = tx_cnt == (AW+1)'(pDepth);
    wire tx_empty  = tx_cnt == '0;
    wire rx_full   = rx_cnt == (AW+1)'(pDepth);
    wire rx_empty  = rx_cnt == '0;
    wire tx_push   = bus.iTxValid & ~tx_full;
    wire tx_pop    = load & ~tx_empty;
    wire rx_push   = store & ~rx_full;
    wire rx_pop    = ~rx_empty & bus.iRxReady;
    wire [7:0] tx_byte = phase == LOAD ? tx_shift[7:0]   :
                         phase == B0   ? tx_shift[15:8]  :
                         phase == B1   ? tx_shift[23:16] :
                         phase == B2   ? tx_shift[31:24] : 8'hFF;

    // Bring the bus clock, select and MOSI lane into iClkA with matching two-flop latency
    always_ff @(posedge iClkA or posedge iReset) begin
        if (iReset) begin
            clk_s    <= 2'b11;
            clk_prev <= 1'b1;
            sel_m    <= ~pSelect;
            sel_s    <= ~pSelect;
            mosi_m   <= '0;
            mosi_s   <= '0;
        end else begin
            clk_s    <= {clk_s[0], bus.iBusClock};
            clk_prev <= clk_s[1];
            sel_m    <= bus.iBusSelect;
            sel_s    <= sel_m;
            mosi_m   <= bus.iBusMOSI;
            mosi_s   <= mosi_m;
        end
    end

    // Frame phase advances on each selected fall; deselect or a stalled bus clock drops back to Idle
    always_ff @(posedge iClkA or posedge iReset) begin
        if (iReset) begin
            phase    <= IDLE;
            idle_cnt <= '0;
        end else if (!selected) begin
            phase    <= IDLE;
            idle_cnt <= '0;
        end else if (fall) begin
            phase    <= next_phase;
            idle_cnt <= '0;
        end else if (timeout) begin
            phase    <= IDLE;
            idle_cnt <= '0;
        end else if (phase != IDLE) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Assemble the RX word byte by byte and load the next TX word at the start of each frame
    always_ff @(posedge iClkA or posedge iReset) begin
        if (iReset) begin
            rx_shift <= '0;
            tx_shift <= '1;
        end else begin
            if (fall && next_phase == B0) rx_shift[7:0]   <= mosi_s;
            if (fall && next_phase == B1) rx_shift[15:8]  <= mosi_s;
            if (fall && next_phase == B2) rx_shift[23:16] <= mosi_s;
            if (fall && next_phase == B3) rx_shift[31:24] <= mosi_s;
            if (load) tx_shift <= tx_empty ? 32'hFFFF_FFFF : tx_mem[tx_rd];
        end
    end

    // Register the MISO lane so it only changes from a clean flop
    always_ff @(posedge iClkA or posedge iReset) begin
        if (iReset) miso <= 8'hFF;
        else        miso <= selected ? tx_byte : 8'hFF;
    end

    // Sticky error flags; a new error in the same cycle as a clear keeps the flag set
    always_ff @(posedge iClkA or posedge iReset) begin
        if (iReset) begin
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            tx_underrun <= (load & tx_empty) | (tx_underrun & ~bus.iClearFlags);
            rx_overrun  <= (store & rx_full) | (rx_overrun & ~bus.iClearFlags);
        end
    end

    // FIFO pointers and counts; push and pop may coincide, pointers wrap modulo pDepth
    always_ff @(posedge iClkA or posedge iReset) begin
        if (iReset) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            tx_wr  <= tx_wr + AW'(tx_push);
            tx_rd  <= tx_rd + AW'(tx_pop);
            tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            rx_wr  <= rx_wr + AW'(rx_push);
            rx_rd  <= rx_rd + AW'(rx_pop);
            rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end

    // FIFO storage needs no reset; the counts gate every read
    always_ff @(posedge iClkA) begin
        if (tx_push) tx_mem[tx_wr] <= bus.iTxData;
        if (rx_push) rx_mem[rx_wr] <= rx_shift;
    end

`ifdef SYSX_SLAVE_IRQ_EN
    logic irq;

    // Ask the master for service while TX words wait or an RX word was lost
    always_ff @(posedge iClkA or posedge iReset) begin
        if (iReset) irq <= 1'b0;
        else        irq <= ~tx_empty | rx_overrun;
    end

    assign bus.oBusInterrupt = irq;
`else
    assign bus.oBusInterrupt = 1'b0;
`endif

    assign bus.oBusMISO    = miso;
    assign bus.oBusDrive   = selected;
    assign bus.oTxReady    = ~tx_full;
    assign bus.oRxValid    = ~rx_empty;
    assign bus.oRxData     = rx_empty ? 32'h0 : rx_mem[rx_rd];
    assign bus.oTxUnderrun = tx_underrun;
    assign bus.oRxOverrun  = rx_overrun;
endmodule

// File: tb/tb_sysx_slave_port.sv
// tb_sysx_slave_port: directed scoreboard bench for sysx_slave_port
module tb_sysx_slave_port;
    localparam logic [1:0] SEL = 2'h1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic exp_und = 1'b0;
    logic exp_ovr = 1'b0;

    sysx_slave_port_if bus_if();

    sysx_slave_port #(.pSelect(SEL), .pDepth(DEPTH), .pIdleTimeout(64)) dut (
        .iClkA(clk),
        .iReset(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq(input string tag);
`ifdef SYSX_SLAVE_IRQ_EN
        chk(tag, {31'b0, bus_if.oBusInterrupt}, {31'b0, tx_q.size() != 0 || exp_ovr});
`else
        chk(tag, {31'b0, bus_if.oBusInterrupt}, 32'h0);
`endif
    endtask

    task automatic push_tx(input logic [31:0] w);
        chk("tx_ready", {31'b0, bus_if.oTxReady}, 32'h1);
        bus_if.iTxData = w;
        bus_if.iTxValid = 1'b1;
        cyc(1);
        bus_if.iTxValid = 1'b0;
        tx_q.push_back(w);
        cyc(2);
    endtask

    task automatic pop_rx();
        logic [31:0] e;
        if (rx_q.size() == 0) begin
            chk("rx_empty", {31'b0, bus_if.oRxValid}, 32'h0);
        end else begin
            e = rx_q.pop_front();
            chk("rx_valid", {31'b0, bus_if.oRxValid}, 32'h1);
            chk("rx_data", bus_if.oRxData, e);
            bus_if.iRxReady = 1'b1;
            cyc(1);
            bus_if.iRxReady = 1'b0;
            cyc(1);
        end
    endtask

    task automatic clear_flags();
        bus_if.iClearFlags = 1'b1;
        cyc(1);
        bus_if.iClearFlags = 1'b0;
        cyc(1);
        exp_und = 1'b0;
        exp_ovr = 1'b0;
        chk("und_clear", {31'b0, bus_if.oTxUnderrun}, 32'h0);
        chk("ovr_clear", {31'b0, bus_if.oRxOverrun}, 32'h0);
    endtask

    // nf bus-clock falls carrying MOSI word w; keep holds select for block mode
    task automatic frame(input logic [31:0] w, input int nf, input bit keep);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        if (bus_if.iBusSelect !== SEL) begin
            bus_if.iBusSelect = SEL;
            cyc(4);
        end
        chk("drive_on", {31'b0, bus_if.oBusDrive}, 32'h1);
        for (int k = 1; k <= nf; k++) begin
            if (k >= 2 && k <= 5) bus_if.iBusMOSI = w[8*(k-2) +: 8];
            cyc(8);
            if (k >= 2 && k <= 5) chk("miso_byte", {24'b0, bus_if.oBusMISO}, {24'b0, m[8*(k-2) +: 8]});
            if (k == 1 || k == 6) chk("miso_ff", {24'b0, bus_if.oBusMISO}, 32'hFF);
            if (k == 1) begin
                if (tx_q.size() != 0) m = tx_q.pop_front();
                else begin
                    m = 32'hFFFF_FFFF;
                    exp_und = 1'b1;
                end
            end
            bus_if.iBusClock = 1'b0;
            cyc(8);
            bus_if.iBusClock = 1'b1;
        end
        if (nf == 7) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(w);
            else exp_ovr = 1'b1;
        end
        chk("underrun", {31'b0, bus_if.oTxUnderrun}, {31'b0, exp_und});
        chk("overrun", {31'b0, bus_if.oRxOverrun}, {31'b0, exp_ovr});
        if (!keep) begin
            cyc(4);
            bus_if.iBusSelect = 2'h0;
            cyc(4);
            chk("drive_off", {31'b0, bus_if.oBusDrive}, 32'h0);
            chk("miso_desel", {24'b0, bus_if.oBusMISO}, 32'hFF);
        end
        chk_irq("irq_frame");
    endtask

    initial begin
        bus_if.iBusClock = 1'b1;
        bus_if.iBusSelect = 2'h0;
        bus_if.iBusMOSI = 8'h00;
        bus_if.iTxData = 32'h0;
        bus_if.iTxValid = 1'b0;
        bus_if.iRxReady = 1'b0;
        bus_if.iClearFlags = 1'b0;
        cyc(3);
        chk("rst_miso", {24'b0, bus_if.oBusMISO}, 32'hFF);
        chk("rst_drive", {31'b0, bus_if.oBusDrive}, 32'h0);
        chk("rst_irq", {31'b0, bus_if.oBusInterrupt}, 32'h0);
        chk("rst_txready", {31'b0, bus_if.oTxReady}, 32'h1);
        chk("rst_rxvalid", {31'b0, bus_if.oRxValid}, 32'h0);
        chk("rst_rxdata", bus_if.oRxData, 32'h0);
        chk("rst_und", {31'b0, bus_if.oTxUnderrun}, 32'h0);
        chk("rst_ovr", {31'b0, bus_if.oRxOverrun}, 32'h0);
        rst = 1'b0;
        cyc(3);

        push_tx(32'hA1B2_C3D4);
        chk_irq("irq_push");
        frame(32'h4433_2211, 7, 1'b0);
        pop_rx();

        frame(32'h5566_7788, 7, 1'b0);
        pop_rx();
        clear_flags();

        for (int i = 0; i < DEPTH + 1; i++) frame(32'h1000_0000 + 32'(i) * 32'h0101_0101, 7, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) pop_rx();
        clear_flags();

        push_tx(32'hCAFE_F00D);
        push_tx(32'h0BAD_BEEF);
        frame(32'hDEAD_0001, 3, 1'b0);
        pop_rx();
        frame(32'h8765_4321, 7, 1'b0);
        pop_rx();

        for (int i = 0; i < DEPTH; i++) push_tx(32'hB000_0000 + 32'(i));
        chk("tx_full", {31'b0, bus_if.oTxReady}, 32'h0);
        frame(32'h0A0B_0C0D, 7, 1'b1);
        frame(32'h1A1B_1C1D, 7, 1'b1);
        frame(32'h2A2B_2C2D, 7, 1'b0);
        for (int i = 0; i < 3; i++) pop_rx();

        frame(32'h3333_3333, 3, 1'b1);
        cyc(80);
        frame(32'h7654_3210, 7, 1'b0);
        pop_rx();
        clear_flags();

        push_tx(32'h1357_9BDF);
        frame(32'h9999_9999, 4, 1'b1);
        rst = 1'b1;
        cyc(2);
        chk("mid_rst_txready", {31'b0, bus_if.oTxReady}, 32'h1);
        chk("mid_rst_rxvalid", {31'b0, bus_if.oRxValid}, 32'h0);
        chk("mid_rst_miso", {24'b0, bus_if.oBusMISO}, 32'hFF);
        rst = 1'b0;
        tx_q.delete();
        rx_q.delete();
        exp_und = 1'b0;
        exp_ovr = 1'b0;
        cyc(4);
        frame(32'hFEDC_BA98, 7, 1'b0);
        pop_rx();
        pop_rx();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
